// File: rtl/fa4_fetch_unit.sv
// FA4 instruction fetch: walks the PC over a nibble-wide synchronous ROM, assembles
// variable-length instructions and owns the return-address stack. Optional macro:
// FA4_FETCH_STACK_CHECK_EN (sticky stack_err, no overwrite on push-when-full).
module fa4_fetch_unit #(
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 3
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] addr_out,
    input  logic [3:0]        data_in,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [3:0]        inst_op,
    output logic [11:0]       inst_arg,
    output logic [1:0]        inst_len,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              jump_en,
    input  logic              call_en,
    input  logic              ret_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              stack_err
);
    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    typedef enum logic [1:0] {ST_FETCH = 2'd0, ST_CAPTURE = 2'd1, ST_HOLD = 2'd2} state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  pc_reg, pc_next;
    logic [1:0]         nib_cnt_reg, len_reg;
    logic [3:0]         op_reg;
    logic [11:0]        arg_reg;
    logic [ADDR_W-1:0]  inst_pc_reg;
    logic [PTR_W-1:0]   sp_reg, sp_next, sp_inc, sp_dec;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [ADDR_W-1:0]  stack_rd [STACK_DEPTH];
    logic               push, handshake, last_nibble, stack_full, stack_empty;
    logic [1:0]         dec_len;

    assign dec_len     = data_in[3] ? (data_in[2] ? 2'd3 : 2'd1) : 2'd0;
    assign last_nibble = (nib_cnt_reg == 2'd0) ? (dec_len == 2'd0) : (nib_cnt_reg == len_reg);

    // sp_reg is the next free slot; when full it also marks the oldest entry.
    assign sp_inc      = (sp_reg == PTR_W'(STACK_DEPTH - 1)) ? '0 : sp_reg + 1'b1;
    assign sp_dec      = (sp_reg == '0) ? PTR_W'(STACK_DEPTH - 1) : sp_reg - 1'b1;
    assign stack_full  = (cnt_reg == CNT_W'(STACK_DEPTH));
    assign stack_empty = (cnt_reg == '0);

    generate
        for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
            logic [ADDR_W-1:0] entry_reg;
            always_ff @(posedge clock) begin
                if (push && sp_reg == PTR_W'(gi)) begin
                    entry_reg <= pc_reg;
                end
            end
            assign stack_rd[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FETCH:   state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = last_nibble ? ST_HOLD : ST_FETCH;
            ST_HOLD:    state_next = handshake ? ST_FETCH : ST_HOLD;
            default:    state_next = ST_FETCH;
        endcase
    end

    always_comb begin
        inst_valid = (state_reg == ST_HOLD);
        handshake  = (state_reg == ST_HOLD) && inst_ready;
    end

`ifdef FA4_FETCH_STACK_CHECK_EN
    logic err_set;
    logic stack_err_reg;
`endif

    always_comb begin
        pc_next  = pc_reg;
        sp_next  = sp_reg;
        cnt_next = cnt_reg;
        push     = 1'b0;
`ifdef FA4_FETCH_STACK_CHECK_EN
        err_set  = 1'b0;
`endif
        if (state_reg == ST_CAPTURE) begin
            pc_next = pc_reg + 1'b1;
        end else if (handshake) begin
            if (ret_en) begin
                if (stack_empty) begin
                    pc_next = '0;
`ifdef FA4_FETCH_STACK_CHECK_EN
                    err_set = 1'b1;
`endif
                end else begin
                    pc_next  = stack_rd[sp_dec];
                    sp_next  = sp_dec;
                    cnt_next = cnt_reg - 1'b1;
                end
            end else if (call_en) begin
                pc_next = jump_addr;
`ifdef FA4_FETCH_STACK_CHECK_EN
                if (stack_full) begin
                    err_set = 1'b1;
                end else begin
                    push     = 1'b1;
                    sp_next  = sp_inc;
                    cnt_next = cnt_reg + 1'b1;
                end
`else
                push    = 1'b1;
                sp_next = sp_inc;
                if (!stack_full) begin
                    cnt_next = cnt_reg + 1'b1;
                end
`endif
            end else if (jump_en) begin
                pc_next = jump_addr;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg      <= '0;
            sp_reg      <= '0;
            cnt_reg     <= '0;
            nib_cnt_reg <= 2'd0;
            len_reg     <= 2'd0;
            op_reg      <= 4'd0;
            arg_reg     <= 12'd0;
            inst_pc_reg <= '0;
        end else begin
            pc_reg  <= pc_next;
            sp_reg  <= sp_next;
            cnt_reg <= cnt_next;
            if (state_reg == ST_CAPTURE) begin
                if (nib_cnt_reg == 2'd0) begin
                    op_reg      <= data_in;
                    inst_pc_reg <= pc_reg;
                    arg_reg     <= 12'd0;
                    len_reg     <= dec_len;
                end else begin
                    arg_reg <= {arg_reg[7:0], data_in};
                end
                nib_cnt_reg <= last_nibble ? 2'd0 : nib_cnt_reg + 2'd1;
            end
        end
    end

`ifdef FA4_FETCH_STACK_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stack_err_reg <= 1'b0;
        end else if (err_set) begin
            stack_err_reg <= 1'b1;
        end
    end
    assign stack_err = stack_err_reg;
`else
    assign stack_err = 1'b0;
`endif

    // addr_out is the PC register itself, so it is registered and stable through stalls.
    assign addr_out = pc_reg;
    assign inst_op  = op_reg;
    assign inst_arg = arg_reg;
    assign inst_len = len_reg;
    assign inst_pc  = inst_pc_reg;
endmodule
